// File: rtl/note_arbiter_if.sv
// note_arbiter_if: bus between the key scanner side and the note arbiter.
//   keys_raw   : raw key levels, 1 = pressed (bit31 = DO4 .. bit0 = SOL6)
//   tick_ms    : 1-cycle strobe once per millisecond
//   note       : one-hot note to the tone generator, 0 = silent
//   note_idx   : bit position of the set bit in note, 0 when silent
//   gate       : 1 while a key is sounding
//   note_start : 1-cycle pulse on every (re)start of a nonzero note
//   sustain    : pedal level, present only with SUSTAIN_PEDAL_EN
// Modports: master = stimulus side, slave = note_arbiter.
interface note_arbiter_if;
    logic [31:0] keys_raw;
    logic        tick_ms;
    logic [31:0] note;
    logic [4:0]  note_idx;
    logic        gate;
    logic        note_start;
`ifdef SUSTAIN_PEDAL_EN
    logic        sustain;

    modport master (output keys_raw, tick_ms, sustain,
                    input  note, note_idx, gate, note_start);
    modport slave  (input  keys_raw, tick_ms, sustain,
                    output note, note_idx, gate, note_start);
`else
    modport master (output keys_raw, tick_ms,
                    input  note, note_idx, gate, note_start);
    modport slave  (input  keys_raw, tick_ms,
                    output note, note_idx, gate, note_start);
`endif
endinterface

// File: rtl/note_arbiter.sv
// note_arbiter: debounces a 32-key vector, selects one key to sound
// (monophonic, newest press wins, highest pitch among simultaneous presses),
// and drives a one-hot note with gate/retrigger strobes and a timed release.
// Optional feature macro: SUSTAIN_PEDAL_EN (adds bus.sustain; pedal down
// holds the note and gate after all keys are released).
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : note_arbiter_if.slave (keys_raw, tick_ms in; note, note_idx,
//          gate, note_start out; sustain in when the feature is enabled)
module note_arbiter #(
    parameter int unsigned DEBOUNCE_MS = 10,
    parameter int unsigned RELEASE_MS  = 200,
    parameter int unsigned CNT_W       = 10
) (
    input  logic           clk,
    input  logic           rst,
    note_arbiter_if.slave  bus
);
    localparam int unsigned KEY_W = 32;
    localparam int unsigned IDX_W = 5;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PLAYING = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [KEY_W-1:0]   keys_last, keys_db, keys_prev;
    logic [CNT_W-1:0]   cnt, rcnt, rcnt_d;
    logic [KEY_W-1:0]   note_q, note_d;
    logic [IDX_W-1:0]   idx_q, idx_d, sel_idx;
    logic               gate_q, gate_d;
    logic               start_q, start_d;
    logic [KEY_W-1:0]   new_press;
    logic               any_press, keys_any, cur_held, sustain_c;

    // Index of the lowest set bit (highest pitch); 0 for an empty vector.
    function automatic logic [IDX_W-1:0] lowest_idx(input logic [KEY_W-1:0] v);
        lowest_idx = '0;
        for (int i = int'(KEY_W) - 1; i >= 0; i--) begin
            if (v[i]) lowest_idx = IDX_W'(i);
        end
    endfunction

`ifdef SUSTAIN_PEDAL_EN
    assign sustain_c = bus.sustain;
`else
    assign sustain_c = 1'b0;
`endif

    // Whole-vector debounce; a changed sample restarts the count and beats a tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            keys_last <= '0;
            keys_db   <= '0;
            keys_prev <= '0;
            cnt       <= '0;
        end else begin
            keys_prev <= keys_db;
            if (bus.keys_raw != keys_last) begin
                keys_last <= bus.keys_raw;
                cnt       <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_MS)) begin
                keys_db <= keys_last;
            end else if (bus.tick_ms) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign new_press = keys_db & ~keys_prev;
    assign any_press = |new_press;
    assign keys_any  = |keys_db;
    assign cur_held  = |(keys_db & note_q);
    assign sel_idx   = any_press ? lowest_idx(new_press) : lowest_idx(keys_db);

    // State register together with the registered outputs and release counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            note_q  <= '0;
            idx_q   <= '0;
            gate_q  <= 1'b0;
            start_q <= 1'b0;
            rcnt    <= '0;
        end else begin
            state   <= state_n;
            note_q  <= note_d;
            idx_q   <= idx_d;
            gate_q  <= gate_d;
            start_q <= start_d;
            rcnt    <= rcnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (any_press) state_n = S_PLAYING;
            end
            S_PLAYING: begin
                if (!any_press && !keys_any && !sustain_c) state_n = S_RELEASE;
            end
            S_RELEASE: begin
                if (any_press)                            state_n = S_PLAYING;
                else if (rcnt == CNT_W'(RELEASE_MS))      state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and the release counter.
    always_comb begin
        note_d  = note_q;
        idx_d   = idx_q;
        start_d = 1'b0;
        rcnt_d  = rcnt;
        gate_d  = (state_n == S_PLAYING);
        case (state)
            S_IDLE: begin
                if (any_press) begin
                    note_d  = KEY_W'(1) << sel_idx;
                    idx_d   = sel_idx;
                    start_d = 1'b1;
                end
            end
            S_PLAYING: begin
                if (any_press) begin
                    note_d  = KEY_W'(1) << sel_idx;
                    idx_d   = sel_idx;
                    start_d = 1'b1;
                end else if (!keys_any) begin
                    if (!sustain_c) rcnt_d = '0;
                end else if (!cur_held && !sustain_c) begin
                    // Sounding key let go while others remain: fall back.
                    note_d  = KEY_W'(1) << sel_idx;
                    idx_d   = sel_idx;
                    start_d = 1'b1;
                end
            end
            S_RELEASE: begin
                if (any_press) begin
                    note_d  = KEY_W'(1) << sel_idx;
                    idx_d   = sel_idx;
                    start_d = 1'b1;
                end else if (rcnt == CNT_W'(RELEASE_MS)) begin
                    note_d = '0;
                    idx_d  = '0;
                end else if (bus.tick_ms) begin
                    rcnt_d = rcnt + CNT_W'(1);
                end
            end
            default: begin
                note_d = '0;
                idx_d  = '0;
            end
        endcase
    end

    assign bus.note       = note_q;
    assign bus.note_idx   = idx_q;
    assign bus.gate       = gate_q;
    assign bus.note_start = start_q;

endmodule

// File: tb/tb_note_arbiter.sv
// tb_note_arbiter: directed stimulus with a note_start scoreboard; expected
// notes are queued at stimulus time and checked by a monitor on each pulse.
module tb_note_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   div   = 0;

    typedef struct packed {
        logic [31:0] note;
        logic [4:0]  idx;
    } exp_t;
    exp_t exp_q[$];

    note_arbiter_if bus();

    note_arbiter #(.DEBOUNCE_MS(2), .RELEASE_MS(3), .CNT_W(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endfunction

    function automatic void expect_note(logic [31:0] n, logic [4:0] i);
        exp_t e;
        e.note = n;
        e.idx  = i;
        exp_q.push_back(e);
    endfunction

    // Monitor: each note_start pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (!rst && bus.note_start === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_note_start: got note=%h, required no pulse", bus.note);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pulse_note", bus.note, e.note);
                chk("pulse_idx", 32'(bus.note_idx), 32'(e.idx));
                chk("pulse_gate", 32'(bus.gate), 32'd1);
            end
        end
    end

    // One clock; inputs change at the falling edge, tick every fourth cycle.
    task automatic cyc();
        @(negedge clk);
        bus.tick_ms = (div == 3);
        div = (div + 1) % 4;
    endtask

    // Runs until n ticks have been issued (the last one lands on the next edge).
    task automatic ticks(int n);
        int seen = 0;
        while (seen < n) begin
            cyc();
            if (bus.tick_ms) seen++;
        end
    endtask

    task automatic settle_press();
        ticks(2);
        repeat (3) cyc();
    endtask

    initial begin
        bus.keys_raw = 32'hFFFF_FFFF;
        bus.tick_ms  = 1'b0;
`ifdef SUSTAIN_PEDAL_EN
        bus.sustain  = 1'b0;
`endif
        // 1: reset with all keys down
        repeat (2) cyc();
        chk("rst_note", bus.note, 32'h0);
        chk("rst_idx", 32'(bus.note_idx), 32'd0);
        chk("rst_gate", 32'(bus.gate), 32'd0);
        chk("rst_start", 32'(bus.note_start), 32'd0);
        rst = 1'b0;
        expect_note(32'h0000_0001, 5'd0);
        ticks(2);
        cyc();
        chk("post_rst_silent", bus.note, 32'h0);
        repeat (3) cyc();
        chk("all_keys_note", bus.note, 32'h0000_0001);
        bus.keys_raw = 32'h0;
        settle_press();
        ticks(4);
        repeat (2) cyc();
        chk("t1_idle_note", bus.note, 32'h0);

        // 3: bouncing key never passes the debouncer
        for (int i = 0; i < 20; i++) begin
            bus.keys_raw = (i % 2 == 0) ? 32'h0040_0000 : 32'h0;
            cyc();
        end
        chk("bounce_note", bus.note, 32'h0);
        chk("bounce_gate", 32'(bus.gate), 32'd0);
        bus.keys_raw = 32'h0;
        ticks(3);
        repeat (3) cyc();

        // 2: single clean press of LA4
        bus.keys_raw = 32'h0040_0000;
        expect_note(32'h0040_0000, 5'd22);
        settle_press();
        chk("la4_note", bus.note, 32'h0040_0000);
        chk("la4_idx", 32'(bus.note_idx), 32'd22);
        chk("la4_gate", 32'(bus.gate), 32'd1);

        // 4: add DO5, then let it go and fall back to LA4
        bus.keys_raw = 32'h0048_0000;
        expect_note(32'h0008_0000, 5'd19);
        settle_press();
        chk("do5_note", bus.note, 32'h0008_0000);
        bus.keys_raw = 32'h0040_0000;
        expect_note(32'h0040_0000, 5'd22);
        settle_press();
        chk("fallback_note", bus.note, 32'h0040_0000);
        chk("fallback_gate", 32'(bus.gate), 32'd1);

        // 5: release all, note held for the release time, then silent
        bus.keys_raw = 32'h0;
        settle_press();
        chk("rel_gate", 32'(bus.gate), 32'd0);
        chk("rel_note_held", bus.note, 32'h0040_0000);
        ticks(3);
        chk("rel_note_still_held", bus.note, 32'h0040_0000);
        repeat (2) cyc();
        chk("rel_done_note", bus.note, 32'h0);
        chk("rel_done_idx", 32'(bus.note_idx), 32'd0);
        chk("rel_done_gate", 32'(bus.gate), 32'd0);

        // 5b: same key pressed again during RELEASE retriggers
        bus.keys_raw = 32'h0040_0000;
        expect_note(32'h0040_0000, 5'd22);
        settle_press();
        bus.keys_raw = 32'h0;
        settle_press();
        chk("rel2_gate", 32'(bus.gate), 32'd0);
        bus.keys_raw = 32'h0040_0000;
        expect_note(32'h0040_0000, 5'd22);
        settle_press();
        chk("repress_gate", 32'(bus.gate), 32'd1);
        chk("repress_note", bus.note, 32'h0040_0000);

`ifdef SUSTAIN_PEDAL_EN
        // 6: pedal holds the note after release, lifting it starts RELEASE
        bus.sustain  = 1'b1;
        bus.keys_raw = 32'h0;
        settle_press();
        chk("sus_gate", 32'(bus.gate), 32'd1);
        chk("sus_note", bus.note, 32'h0040_0000);
        ticks(4);
        chk("sus_gate_long", 32'(bus.gate), 32'd1);
        bus.sustain = 1'b0;
        cyc();
        chk("sus_off_gate", 32'(bus.gate), 32'd0);
        chk("sus_off_note", bus.note, 32'h0040_0000);
        ticks(4);
        repeat (2) cyc();
        chk("sus_done_note", bus.note, 32'h0);
`else
        bus.keys_raw = 32'h0;
        settle_press();
        ticks(4);
        repeat (2) cyc();
        chk("final_idle_note", bus.note, 32'h0);
`endif
        repeat (4) cyc();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
